branch_predictor_table: RTL

Parametrised successor to the fixed 32-entry 2-bit branch history table. It is a direct-mapped table of N-bit saturating counters, with an optional global-history (gshare) index hash. Lookups come from the fetch stage with one-cycle registered latency, and updates come from the execute stage on branch resolution. After reset, a sequential init sweep loads every counter to weakly-not-taken before the table accepts traffic.

---
 rtl/bp_pkg.sv | 12 +
 rtl/bp_index_hash.sv | 15 +
 rtl/branch_predictor_table.sv | 68 ++++++
 3 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared FSM states and saturating-counter helpers for branch predictors
package bp_pkg;
  typedef enum logic {BP_INIT, BP_RUN} bp_state_e;
  function automatic int ctr_next(input int ctr, input logic taken, input int bits);
    int max_v;
    max_v = (1 << bits) - 1;
    return taken ? ((ctr >= max_v) ? max_v : ctr + 1) : ((ctr <= 0) ? 0 : ctr - 1);
  endfunction
  function automatic int ctr_init(input int bits);
    return (bits == 1) ? 0 : (1 << (bits - 1)) - 1;
  endfunction
endpackage

// File: rtl/bp_index_hash.sv
// bp_index_hash: PC word index optionally XORed with global history (gshare)
module bp_index_hash #(
  parameter int IDX_BITS = 5,
  parameter int GHR_BITS = 0,
  parameter int PC_BITS = 32,
  localparam int GW = (GHR_BITS > 0) ? GHR_BITS : 1
) (
  input logic [PC_BITS-1:0] pc,
  input logic [GW-1:0] ghr,
  output logic [IDX_BITS-1:0] idx
);
  logic unused_bits;
  assign unused_bits = ^{pc[PC_BITS-1:IDX_BITS+2], pc[1:0], ghr};
  assign idx = (GHR_BITS > 0) ? pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr) : pc[IDX_BITS+1:2];
endmodule

// File: rtl/branch_predictor_table.sv
// branch_predictor_table: direct-mapped saturating-counter BHT with optional gshare and init sweep
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 0,
  parameter int PC_BITS = 32,
  localparam int IDX_BITS = $clog2(ENTRIES)
) (
  input logic clk,
  input logic srst,
  input logic en,
  output logic ready,
  input logic lookup_valid,
  input logic [PC_BITS-1:0] lookup_pc,
  output logic pred_valid,
  output logic pred_taken,
  output logic [IDX_BITS-1:0] pred_index,
  input logic upd_valid,
  input logic [IDX_BITS-1:0] upd_index,
  input logic upd_taken
);
  localparam int GW = (GHR_BITS > 0) ? GHR_BITS : 1;
  bp_state_e state, state_nxt;
  logic [IDX_BITS-1:0] init_idx, lk_idx, w_idx;
  logic [GW-1:0] ghr;
  logic [CTR_BITS-1:0] tbl [ENTRIES];
  logic [CTR_BITS-1:0] w_data, rd_ctr;
  logic lk_acc, upd_acc, sweep, w_en;
  bp_index_hash #(.IDX_BITS(IDX_BITS), .GHR_BITS(GHR_BITS), .PC_BITS(PC_BITS)) u_hash (
    .pc(lookup_pc),
    .ghr(ghr),
    .idx(lk_idx)
  );
  always_comb begin
    ready = state == BP_RUN;
    sweep = en && state == BP_INIT;
    lk_acc = lookup_valid && en && ready;
    upd_acc = upd_valid && en && ready;
    w_en = sweep || upd_acc;
    w_idx = sweep ? init_idx : upd_index;
    w_data = sweep ? CTR_BITS'(ctr_init(CTR_BITS))
                   : CTR_BITS'(ctr_next(int'(tbl[upd_index]), upd_taken, CTR_BITS));
    rd_ctr = (upd_acc && upd_index == lk_idx) ? w_data : tbl[lk_idx];
    state_nxt = (sweep && init_idx == IDX_BITS'(ENTRIES - 1)) ? BP_RUN : state;
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state <= BP_INIT;
      init_idx <= '0;
      ghr <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_index <= '0;
    end else begin
      state <= state_nxt;
      init_idx <= sweep ? init_idx + IDX_BITS'(1) : init_idx;
      ghr <= upd_acc ? GW'({ghr, upd_taken}) : ghr;
      pred_valid <= lk_acc;
      pred_taken <= lk_acc ? rd_ctr[CTR_BITS-1] : pred_taken;
      pred_index <= lk_acc ? lk_idx : pred_index;
    end
  end
  always_ff @(posedge clk) begin
    if (!srst && w_en) tbl[w_idx] <= w_data;
  end
endmodule
